// File: rtl/axi_s2mm_io.sv
`default_nettype none
// ============================================================================
// Module      : axi_s2mm_io
// Description : Stream-to-memory writer. On a trigger, drains whole stream
//               beats from S_AXIS and writes them through M_AXI AW/W/B to
//               [start_addr, start_addr+bytes_to_write]. Partial edge beats
//               are masked with wstrb. Bursts split at C_AXI_MAX_BURST and
//               at 4 KiB boundaries.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_s2mm_io #(
    parameter int C_AXI_WIDTH      = 128,
    parameter int C_AXI_ADDR_WIDTH = 64,
    parameter int C_AXI_MAX_BURST  = 255
) (
    input  logic                          clk,
    input  logic                          rst_n,
    output logic                          busy,
    output logic [1:0]                    response,
    output logic                          length_error,
    input  logic                          trigger,
    input  logic [C_AXI_ADDR_WIDTH-1:0]   start_addr,
    input  logic [15:0]                   bytes_to_write,
    output logic [C_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [C_AXI_WIDTH-1:0]        m_axi_wdata,
    output logic [C_AXI_WIDTH/8-1:0]      m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready,
    input  logic [C_AXI_WIDTH-1:0]        s_axis_tdata,
    input  logic                          s_axis_tlast,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready
);

    localparam int c_bytes = C_AXI_WIDTH / 8;
    localparam int c_lsb   = $clog2(c_bytes);
    localparam int AW      = C_AXI_ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CALC = 3'd1,
        S_ADDR = 3'd2,
        S_DATA = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t                 r_state;
    logic                   r_busy;
    logic [1:0]             r_response;
    logic                   r_length_error;
    logic [AW-1:0]          r_addr;
    logic [c_lsb-1:0]       r_start_lane;
    logic [c_lsb-1:0]       r_end_lane;
    logic [16:0]            r_beats_left;
    logic                   r_first_burst;
    logic                   r_early;
    logic [8:0]             r_beat_cnt;
    logic [AW-1:0]          r_awaddr;
    logic [7:0]             r_awlen;
    logic [2:0]             r_awsize;
    logic                   r_awvalid;
    logic [C_AXI_WIDTH-1:0] r_wdata;
    logic [c_bytes-1:0]     r_wstrb;
    logic                   r_wlast;
    logic                   r_wvalid;
    logic                   r_bready;

    logic [16:0]            w_trig_sum;
    logic [AW-1:0]          w_aligned;
    logic [12:0]            w_4k_beats;
    logic [12:0]            w_4k_m1;
    logic [16:0]            w_bl_m1;
    logic [7:0]             w_len;
    logic [16:0]            w_burst_beats;
    logic [c_bytes-1:0]     w_first_mask;
    logic [c_bytes-1:0]     w_last_mask;
    logic [c_bytes-1:0]     w_strb_new;
    logic                   w_is_first;
    logic                   w_is_final;
    logic                   w_more;
    logic                   w_slot_free;
    logic                   w_load;
    logic [1:0]             w_bresp_code;

    assign w_trig_sum    = 17'(start_addr[c_lsb-1:0]) + 17'(bytes_to_write);
    assign w_aligned     = {r_addr[AW-1:c_lsb], {c_lsb{1'b0}}};
    assign w_4k_beats    = (13'h1000 - {1'b0, w_aligned[11:0]}) >> c_lsb;
    assign w_4k_m1       = w_4k_beats - 13'd1;
    assign w_bl_m1       = r_beats_left - 17'd1;
    assign w_burst_beats = 17'(r_awlen) + 17'd1;

    // Burst length: smallest of the configured cap, the remaining beats and the room left before the 4 KiB page ends
    always_comb begin
        w_len = 8'(C_AXI_MAX_BURST);
        if (w_bl_m1 < 17'(w_len))
            w_len = w_bl_m1[7:0];
        if (w_4k_m1 < 13'(w_len))
            w_len = w_4k_m1[7:0];
    end

    // Lane masks for the partial first and final beats
    always_comb begin
        w_first_mask = '0;
        w_last_mask  = '0;
        for (int i = 0; i < c_bytes; i++) begin
            w_first_mask[i] = (c_lsb'(i) >= r_start_lane);
            w_last_mask[i]  = (c_lsb'(i) <= r_end_lane);
        end
    end

    assign w_is_first   = r_first_burst && (r_beat_cnt == 9'd0);
    assign w_is_final   = (r_beats_left == w_burst_beats) && (r_beat_cnt == {1'b0, r_awlen});
    assign w_more       = (r_beat_cnt <= {1'b0, r_awlen});
    assign w_slot_free  = !r_wvalid || m_axi_wready;
    // After an early tlast the rest of the transfer is filled locally without touching the stream
    assign w_load       = (r_state == S_DATA) && w_more && w_slot_free && (r_early || s_axis_tvalid);
    assign w_bresp_code = m_axi_bresp[1] ? m_axi_bresp : 2'b01;

    // Strobe for the beat being loaded: all lanes, trimmed at the transfer edges, empty once the stream ended early
    always_comb begin
        w_strb_new = '1;
        if (w_is_first)
            w_strb_new = w_strb_new & w_first_mask;
        if (w_is_final)
            w_strb_new = w_strb_new & w_last_mask;
        if (r_early)
            w_strb_new = '0;
    end

    // Transfer sequencer: burst planning, AW issue, registered W stage and B collection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_busy         <= 1'b0;
            r_response     <= 2'd0;
            r_length_error <= 1'b0;
            r_addr         <= '0;
            r_start_lane   <= '0;
            r_end_lane     <= '0;
            r_beats_left   <= '0;
            r_first_burst  <= 1'b0;
            r_early        <= 1'b0;
            r_beat_cnt     <= '0;
            r_awaddr       <= '0;
            r_awlen        <= '0;
            r_awsize       <= '0;
            r_awvalid      <= 1'b0;
            r_wdata        <= '0;
            r_wstrb        <= '0;
            r_wlast        <= 1'b0;
            r_wvalid       <= 1'b0;
            r_bready       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (trigger) begin
                        r_busy         <= 1'b1;
                        r_response     <= 2'd0;
                        r_length_error <= 1'b0;
                        r_early        <= 1'b0;
                        r_first_burst  <= 1'b1;
                        r_addr         <= start_addr;
                        r_start_lane   <= start_addr[c_lsb-1:0];
                        r_end_lane     <= w_trig_sum[c_lsb-1:0];
                        r_beats_left   <= (w_trig_sum >> c_lsb) + 17'd1;
                        r_state        <= S_CALC;
                    end
                end
                S_CALC: begin
                    // r_addr keeps the caller's byte offset only before the first burst
                    r_awaddr   <= r_addr;
                    r_awlen    <= w_len;
                    r_awsize   <= 3'(c_lsb);
                    r_awvalid  <= 1'b1;
                    r_beat_cnt <= '0;
                    r_state    <= S_ADDR;
                end
                S_ADDR: begin
                    if (m_axi_awready) begin
                        r_awvalid <= 1'b0;
                        r_state   <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_load) begin
                        r_wvalid   <= 1'b1;
                        r_wdata    <= r_early ? '0 : s_axis_tdata;
                        r_wstrb    <= w_strb_new;
                        r_wlast    <= (r_beat_cnt == {1'b0, r_awlen});
                        r_beat_cnt <= r_beat_cnt + 9'd1;
                        if (!r_early && s_axis_tlast && !w_is_final) begin
                            r_early        <= 1'b1;
                            r_length_error <= 1'b1;
                        end
                    end else if (r_wvalid && m_axi_wready) begin
                        r_wvalid <= 1'b0;
                    end
                    if (r_wvalid && m_axi_wready && r_wlast) begin
                        r_bready <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (m_axi_bvalid) begin
                        r_bready      <= 1'b0;
                        r_first_burst <= 1'b0;
                        if (!r_response[1])
                            r_response <= w_bresp_code;
                        r_addr       <= w_aligned + (AW'(w_burst_beats) << c_lsb);
                        r_beats_left <= r_beats_left - w_burst_beats;
                        if (r_beats_left == w_burst_beats) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_CALC;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign response      = r_response;
    assign length_error  = r_length_error;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awlen   = r_awlen;
    assign m_axi_awsize  = r_awsize;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = r_wstrb;
    assign m_axi_wlast   = r_wlast;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = r_bready;
    assign s_axis_tready = (r_state == S_DATA) && w_more && !r_early && w_slot_free;

endmodule
`default_nettype wire

// File: tb/tb_axi_s2mm_io.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_s2mm_io
// Description : Directed bench for axi_s2mm_io with a behavioural AXI slave
//               and stream source; beats are logged and compared with
//               hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_s2mm_io;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          busy;
    logic [1:0]    response;
    logic          length_error;
    logic          trigger = 1'b0;
    logic [63:0]   start_addr = '0;
    logic [15:0]   bytes_to_write = '0;
    logic [63:0]   m_axi_awaddr;
    logic [7:0]    m_axi_awlen;
    logic [2:0]    m_axi_awsize;
    logic          m_axi_awvalid;
    logic          m_axi_awready = 1'b0;
    logic [127:0]  m_axi_wdata;
    logic [15:0]   m_axi_wstrb;
    logic          m_axi_wlast;
    logic          m_axi_wvalid;
    logic          m_axi_wready = 1'b0;
    logic [1:0]    m_axi_bresp = 2'b00;
    logic          m_axi_bvalid = 1'b0;
    logic          m_axi_bready;
    logic [127:0]  s_axis_tdata = '0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;

    always #5 clk = ~clk;

    axi_s2mm_io #(
        .C_AXI_WIDTH      (128),
        .C_AXI_ADDR_WIDTH (64),
        .C_AXI_MAX_BURST  (255)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .busy           (busy),
        .response       (response),
        .length_error   (length_error),
        .trigger        (trigger),
        .start_addr     (start_addr),
        .bytes_to_write (bytes_to_write),
        .m_axi_awaddr   (m_axi_awaddr),
        .m_axi_awlen    (m_axi_awlen),
        .m_axi_awsize   (m_axi_awsize),
        .m_axi_awvalid  (m_axi_awvalid),
        .m_axi_awready  (m_axi_awready),
        .m_axi_wdata    (m_axi_wdata),
        .m_axi_wstrb    (m_axi_wstrb),
        .m_axi_wlast    (m_axi_wlast),
        .m_axi_wvalid   (m_axi_wvalid),
        .m_axi_wready   (m_axi_wready),
        .m_axi_bresp    (m_axi_bresp),
        .m_axi_bvalid   (m_axi_bvalid),
        .m_axi_bready   (m_axi_bready),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tlast   (s_axis_tlast),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tready  (s_axis_tready)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [127:0] pat(input int k);
        return {32'(k) + 32'h3000_0000, 32'(k) + 32'h2000_0000,
                32'(k) + 32'h1000_0000, 32'(k) + 32'hA500_0000};
    endfunction

    // Slave/source configuration and transaction log
    bit          rnd      = 1'b0;
    bit          wr_block = 1'b0;
    int          tlast_idx = -1;
    logic [1:0]  bresp_cfg [0:31];
    logic [63:0] aw_addr [0:31];
    logic [7:0]  aw_len  [0:31];
    int          aw_b    [0:31];
    logic [127:0] w_data [0:4095];
    logic [15:0]  w_strb [0:4095];
    logic         w_last [0:4095];
    int aw_n = 0, w_n = 0, b_n = 0, pend_b = 0, s_idx = 0;
    int cyc = 0, last_b_edge = 0, done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic clear_log();
        aw_n = 0; w_n = 0; b_n = 0; s_idx = 0; tlast_idx = -1;
        for (int i = 0; i < 32; i++) bresp_cfg[i] = 2'b00;
    endtask

    // Drive slave/source inputs on the falling edge, log handshakes just before the rising edge
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) pend_b = 0;
            m_axi_awready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            m_axi_wready  = wr_block ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            m_axi_bvalid  = (pend_b > 0) && (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            m_axi_bresp   = bresp_cfg[b_n % 32];
            s_axis_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_axis_tdata  = pat(s_idx);
            s_axis_tlast  = (s_idx == tlast_idx);
            #4;
            if (rst_n) begin
                if (m_axi_awvalid && m_axi_awready) begin
                    if (aw_n < 32) begin
                        aw_addr[aw_n] = m_axi_awaddr;
                        aw_len[aw_n]  = m_axi_awlen;
                        aw_b[aw_n]    = b_n;
                    end
                    aw_n++;
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    if (w_n < 4096) begin
                        w_data[w_n] = m_axi_wdata;
                        w_strb[w_n] = m_axi_wstrb;
                        w_last[w_n] = m_axi_wlast;
                    end
                    w_n++;
                    if (m_axi_wlast) pend_b++;
                end
                if (m_axi_bvalid && m_axi_bready) begin
                    pend_b--;
                    b_n++;
                    last_b_edge = cyc + 1;
                end
                if (s_axis_tvalid && s_axis_tready) s_idx++;
            end
        end
    end

    task automatic run_xfer(input logic [63:0] a, input logic [15:0] n, input int budget);
        @(negedge clk);
        start_addr = a; bytes_to_write = n; trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (!busy) break;
            @(negedge clk);
        end
        done_cyc = cyc;
        if (busy) check("timeout_busy", busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_resp", response, 2'd0);
        check("rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_bready, s_axis_tready}, 4'b0);
        check("rst_aw", {m_axi_awaddr, m_axi_awlen, m_axi_awsize}, '0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Aligned 64 bytes: one burst of 4 full beats
        clear_log();
        run_xfer(64'h1000, 16'd63, 200);
        check("t1_aw_n", aw_n, 1);
        check("t1_awaddr", aw_addr[0], 64'h1000);
        check("t1_awlen", aw_len[0], 8'd3);
        check("t1_w_n", w_n, 4);
        for (int j = 0; j < 4; j++) begin
            check("t1_strb", w_strb[j], 16'hFFFF);
            check("t1_data", w_data[j], pat(j));
            check("t1_last", w_last[j], (j == 3));
        end
        check("t1_resp", response, 2'd1);
        check("t1_lenerr", length_error, 1'b0);

        // Unaligned 20 bytes: partial first and last strobes
        clear_log();
        run_xfer(64'h1003, 16'd19, 200);
        check("t2_awaddr", aw_addr[0], 64'h1003);
        check("t2_awlen", aw_len[0], 8'd1);
        check("t2_w_n", w_n, 2);
        check("t2_strb0", w_strb[0], 16'hFFF8);
        check("t2_strb1", w_strb[1], 16'h007F);
        check("t2_busy_fall", done_cyc, last_b_edge);

        // 4K split with SLVERR then OKAY, random backpressure
        clear_log();
        rnd = 1'b1;
        bresp_cfg[0] = 2'b10;
        bresp_cfg[1] = 2'b00;
        run_xfer(64'h0FE0, 16'd63, 1000);
        check("t3_aw_n", aw_n, 2);
        check("t3_awaddr0", aw_addr[0], 64'h0FE0);
        check("t3_awlen0", aw_len[0], 8'd1);
        check("t3_awaddr1", aw_addr[1], 64'h1000);
        check("t3_awlen1", aw_len[1], 8'd1);
        check("t3_aw0_after_b", aw_b[0], 0);
        check("t3_aw1_after_b", aw_b[1], 1);
        check("t3_w_n", w_n, 4);
        for (int j = 0; j < 4; j++) begin
            check("t3_data", w_data[j], pat(j));
            check("t3_last", w_last[j], (j == 1 || j == 3));
        end
        check("t3_resp", response, 2'd2);

        // Early tlast on beat 2 of 4
        clear_log();
        tlast_idx = 1;
        run_xfer(64'h2000, 16'd63, 1000);
        check("t4_w_n", w_n, 4);
        check("t4_strb0", w_strb[0], 16'hFFFF);
        check("t4_strb1", w_strb[1], 16'hFFFF);
        check("t4_strb2", w_strb[2], 16'h0000);
        check("t4_strb3", w_strb[3], 16'h0000);
        check("t4_data1", w_data[1], pat(1));
        check("t4_data2", w_data[2], '0);
        check("t4_data3", w_data[3], '0);
        check("t4_consumed", s_idx, 2);
        check("t4_lenerr", length_error, 1'b1);
        check("t4_resp", response, 2'd1);
        rnd = 1'b0;

        // Single byte-range beat: lanes 5..7, error flags cleared by the new trigger
        clear_log();
        run_xfer(64'h1005, 16'd2, 200);
        check("t5_awaddr", aw_addr[0], 64'h1005);
        check("t5_awlen", aw_len[0], 8'd0);
        check("t5_strb", w_strb[0], 16'h00E0);
        check("t5_lenerr", length_error, 1'b0);

        // Full 64 KiB: 16 bursts of 256 beats on 4K pages
        clear_log();
        run_xfer(64'h0, 16'd65535, 6000);
        check("t6_aw_n", aw_n, 16);
        for (int i = 0; i < 16; i++) begin
            check("t6_awaddr", aw_addr[i], 64'(i) * 64'h1000);
            check("t6_awlen", aw_len[i], 8'd255);
            check("t6_aw_after_b", aw_b[i], i);
        end
        check("t6_w_n", w_n, 4096);
        for (int j = 0; j < 4096; j++) begin
            if (w_data[j] !== pat(j) || w_strb[j] !== 16'hFFFF || w_last[j] !== ((j % 256) == 255))
                check("t6_beat", {w_last[j], w_strb[j], w_data[j][31:0]},
                      {((j % 256) == 255), 16'hFFFF, pat(j)[31:0]});
        end
        check("t6_beats_ok", w_n == 4096, 1'b1);

        // Reset while a beat is stuck in the W stage
        clear_log();
        wr_block = 1'b1;
        @(negedge clk);
        start_addr = 64'h1000; bytes_to_write = 16'd63; trigger = 1'b1;
        @(negedge clk);
        trigger = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (m_axi_wvalid) break;
            @(negedge clk);
        end
        check("t7_wvalid_seen", m_axi_wvalid, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("t7_rst_busy", {busy, response, length_error}, 4'b0);
        check("t7_rst_valids", {m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready, s_axis_tready}, 5'b0);
        check("t7_rst_w", {m_axi_wstrb, m_axi_wdata}, '0);
        check("t7_rst_aw", {m_axi_awaddr, m_axi_awlen, m_axi_awsize}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_block = 1'b0;
        repeat (2) @(negedge clk);
        clear_log();
        run_xfer(64'h3000, 16'd31, 200);
        check("t7_after_aw", aw_addr[0], 64'h3000);
        check("t7_after_w_n", w_n, 2);
        check("t7_after_resp", response, 2'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
